// File: rtl/alu_mdu.sv
// Execute-stage unit: registered single-cycle ALU plus an iterative multiply/divide
// unit that owns the architectural HI/LO registers and stalls the pipe while busy.
module alu_mdu #(
   parameter int W       = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               in_valid,
   input  logic [5:0]         op,
   input  logic [W-1:0]       a,
   input  logic [W-1:0]       b,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               stall,
   output logic               out_valid,
   output logic [W-1:0]       out,
   output logic               ovf,
   output logic               illegal,
   output logic               div_by_zero,
   output logic [W-1:0]       hi,
   output logic [W-1:0]       lo
);

   localparam logic [5:0] OP_SLL   = 6'b000000;
   localparam logic [5:0] OP_SRL   = 6'b000010;
   localparam logic [5:0] OP_SRA   = 6'b000011;
   localparam logic [5:0] OP_SLLV  = 6'b000100;
   localparam logic [5:0] OP_SRLV  = 6'b000110;
   localparam logic [5:0] OP_SRAV  = 6'b000111;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_MFHI  = 6'b010000;
   localparam logic [5:0] OP_MTHI  = 6'b010001;
   localparam logic [5:0] OP_MFLO  = 6'b010010;
   localparam logic [5:0] OP_MTLO  = 6'b010011;
   localparam logic [5:0] OP_MULT  = 6'b011000;
   localparam logic [5:0] OP_MULTU = 6'b011001;
   localparam logic [5:0] OP_DIV   = 6'b011010;
   localparam logic [5:0] OP_DIVU  = 6'b011011;
   localparam logic [5:0] OP_ADD   = 6'b100000;
   localparam logic [5:0] OP_ADDU  = 6'b100001;
   localparam logic [5:0] OP_SUB   = 6'b100010;
   localparam logic [5:0] OP_SUBU  = 6'b100011;
   localparam logic [5:0] OP_AND   = 6'b100100;
   localparam logic [5:0] OP_OR    = 6'b100101;
   localparam logic [5:0] OP_XOR   = 6'b100110;
   localparam logic [5:0] OP_NOR   = 6'b100111;
   localparam logic [5:0] OP_SLT   = 6'b101010;
   localparam logic [5:0] OP_SLTU  = 6'b101011;

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   function automatic logic add_ovf(input logic signed [W-1:0] x, input logic signed [W-1:0] y,
                                    input logic [W-1:0] s);
      return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
   endfunction

   function automatic logic sub_ovf(input logic signed [W-1:0] x, input logic signed [W-1:0] y,
                                    input logic [W-1:0] s);
      return (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
   endfunction

   function automatic logic [W-1:0] apply_sign(input logic [W-1:0] x, input logic neg);
      return neg ? -x : x;
   endfunction

   state_t               r_state, w_state_n;
   logic [SHAMT_W-1:0]   r_cnt;
   logic                 r_vld_p1, r_ovf_p1, r_ill_p1, r_dbz_p1;
   logic [W-1:0]         r_out_p1, r_hi, r_lo;

   // MDU working state, private so HI/LO stay stable while busy
   logic [W-1:0]         r_acc, r_quo, r_dvs, r_a_raw;
   logic                 r_is_div, r_neg_q, r_neg_r, r_dbz;

   logic                 w_accept, w_gpr, w_mdu, w_mthi, w_mtlo, w_ovf, w_ill, w_signed;
   logic [W-1:0]         w_res, w_sum, w_diff;
   logic signed [W-1:0]  w_a_s, w_b_s;
   logic [SHAMT_W-1:0]   w_vamt;
   logic [W:0]           w_madd, w_shift;
   logic [W-1:0]         w_trial, w_hi_n, w_lo_n, w_fin_hi, w_fin_lo;
   logic                 w_qbit, w_last;
   logic [2*W-1:0]       w_prod;

   assign stall       = (r_state == S_BUSY);
   assign w_accept    = in_valid && !stall;
   assign out_valid   = r_vld_p1;
   assign out         = r_out_p1;
   assign ovf         = r_ovf_p1;
   assign illegal     = r_ill_p1;
   assign div_by_zero = r_dbz_p1;
   assign hi          = r_hi;
   assign lo          = r_lo;

   assign w_a_s    = a;
   assign w_b_s    = b;
   assign w_sum    = a + b;
   assign w_diff   = a - b;
   assign w_vamt   = a[SHAMT_W-1:0];
   assign w_signed = (op == OP_MULT) || (op == OP_DIV);
   assign w_last   = (r_state == S_BUSY) && (r_cnt == SHAMT_W'(W - 1));

   always_comb begin
      w_res  = '0;
      w_gpr  = 1'b1;
      w_mdu  = 1'b0;
      w_mthi = 1'b0;
      w_mtlo = 1'b0;
      w_ovf  = 1'b0;
      w_ill  = 1'b0;
      case (op)
         OP_ADD:   begin w_res = w_sum;  w_ovf = add_ovf(w_a_s, w_b_s, w_sum);  end
         OP_ADDU:  w_res = w_sum;
         OP_SUB:   begin w_res = w_diff; w_ovf = sub_ovf(w_a_s, w_b_s, w_diff); end
         OP_SUBU:  w_res = w_diff;
         OP_AND:   w_res = a & b;
         OP_OR:    w_res = a | b;
         OP_XOR:   w_res = a ^ b;
         OP_NOR:   w_res = ~(a | b);
         OP_SLT:   w_res = {{(W-1){1'b0}}, (w_a_s < w_b_s)};
         OP_SLTU:  w_res = {{(W-1){1'b0}}, (a < b)};
         OP_SLL:   w_res = b << shamt;
         OP_SRL:   w_res = b >> shamt;
         OP_SRA:   w_res = w_b_s >>> shamt;
         OP_SLLV:  w_res = b << w_vamt;
         OP_SRLV:  w_res = b >> w_vamt;
         OP_SRAV:  w_res = w_b_s >>> w_vamt;
         OP_LUI:   w_res = b << (W / 2);
         OP_MFHI:  w_res = r_hi;
         OP_MFLO:  w_res = r_lo;
         OP_MTHI:  begin w_gpr = 1'b0; w_mthi = 1'b1; end
         OP_MTLO:  begin w_gpr = 1'b0; w_mtlo = 1'b1; end
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin w_gpr = 1'b0; w_mdu = 1'b1; end
         default:  begin w_res = '1; w_ill = 1'b1; end
      endcase
   end

   // One MDU step: shift-add for multiply, restoring subtract for divide
   always_comb begin
      w_madd  = {1'b0, r_acc} + (r_quo[0] ? {1'b0, r_dvs} : {(W+1){1'b0}});
      w_shift = {r_acc, r_quo[W-1]};
      w_qbit  = (w_shift >= {1'b0, r_dvs});
      w_trial = w_shift[W-1:0] - r_dvs;
      if (r_is_div) begin
         w_hi_n = w_qbit ? w_trial : w_shift[W-1:0];
         w_lo_n = {r_quo[W-2:0], w_qbit};
      end else begin
         w_hi_n = w_madd[W:1];
         w_lo_n = {w_madd[0], r_quo[W-1:1]};
      end
      w_prod = r_neg_q ? -{w_hi_n, w_lo_n} : {w_hi_n, w_lo_n};
      if (!r_is_div) begin
         w_fin_hi = w_prod[2*W-1:W];
         w_fin_lo = w_prod[W-1:0];
      end else if (r_dbz) begin
         w_fin_hi = r_a_raw;
         w_fin_lo = '1;
      end else begin
         w_fin_hi = apply_sign(w_hi_n, r_neg_r);
         w_fin_lo = apply_sign(w_lo_n, r_neg_q);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_state_n;
   end

   always_comb begin
      w_state_n = r_state;
      case (r_state)
         S_IDLE: if (w_accept && w_mdu) w_state_n = S_BUSY;
         S_BUSY: if (w_last)            w_state_n = S_IDLE;
      endcase
   end

   // Result stage p1 and architectural HI/LO
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_vld_p1 <= 1'b0;
         r_ovf_p1 <= 1'b0;
         r_ill_p1 <= 1'b0;
         r_dbz_p1 <= 1'b0;
         r_out_p1 <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_cnt    <= '0;
      end else begin
         r_vld_p1 <= w_accept && w_gpr;
         r_ovf_p1 <= w_accept && w_gpr && w_ovf;
         r_ill_p1 <= w_accept && w_ill;
         r_dbz_p1 <= w_last && r_is_div && r_dbz;
         if (w_accept && w_gpr)  r_out_p1 <= w_res;
         if (w_accept && w_mthi) r_hi <= a;
         if (w_accept && w_mtlo) r_lo <= a;
         if (w_last) begin
            r_hi <= w_fin_hi;
            r_lo <= w_fin_lo;
         end
         if (stall) r_cnt <= r_cnt + 1'b1;
         else       r_cnt <= '0;
      end
   end

   // Signed operations run on magnitudes; signs are reapplied on the final edge
   always_ff @(posedge CLK) begin
      if (w_accept && w_mdu) begin
         r_acc    <= '0;
         r_quo    <= apply_sign(a, w_signed && a[W-1]);
         r_dvs    <= apply_sign(b, w_signed && b[W-1]);
         r_is_div <= op[1];
         r_neg_q  <= w_signed && (a[W-1] ^ b[W-1]);
         r_neg_r  <= w_signed && a[W-1];
         r_dbz    <= op[1] && (b == '0);
         r_a_raw  <= a;
      end else if (stall) begin
         r_acc <= w_hi_n;
         r_quo <= w_lo_n;
      end
   end

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: randomized ops with a scoreboard fed by a wide-integer
// reference model; a separate monitor compares GPR results and MDU completions.
module tb_alu_mdu;

   logic        CLK = 1'b0;
   logic        RST;
   logic        in_valid;
   logic [5:0]  op;
   logic [31:0] a, b;
   logic [4:0]  shamt;
   logic        stall, out_valid, ovf, illegal, div_by_zero;
   logic [31:0] out, hi, lo;

   logic        v16;
   logic [5:0]  op16;
   logic [15:0] a16, b16;
   logic [3:0]  sh16;
   logic        stall16, ov16, ovf16, ill16, dbz16;
   logic [15:0] out16, hi16, lo16;

   always #5 CLK = ~CLK;

   alu_mdu #(.W(32), .SHAMT_W(5)) u_dut (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .op(op), .a(a), .b(b), .shamt(shamt),
      .stall(stall), .out_valid(out_valid), .out(out), .ovf(ovf), .illegal(illegal),
      .div_by_zero(div_by_zero), .hi(hi), .lo(lo));

   alu_mdu #(.W(16), .SHAMT_W(4)) u_dut16 (
      .CLK(CLK), .RST(RST), .in_valid(v16), .op(op16), .a(a16), .b(b16), .shamt(sh16),
      .stall(stall16), .out_valid(ov16), .out(out16), .ovf(ovf16), .illegal(ill16),
      .div_by_zero(dbz16), .hi(hi16), .lo(lo16));

   typedef struct packed {
      logic [31:0] out;
      logic        ovf;
      logic        ill;
   } gexp_t;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } mexp_t;

   gexp_t       gq[$];
   mexp_t       mq[$];
   gexp_t       ge;
   mexp_t       me;
   logic [31:0] m_hi = '0, m_lo = '0;
   int          n_checks = 0, n_pass = 0;
   int          stall_cnt = 0;
   bit          prev_stall = 1'b0;
   bit          skip_mdu = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      else n_pass++;
   endtask

   // Reference model: plain 64-bit integer arithmetic on the architectural rules
   task automatic model_op(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [4:0] s);
      logic signed [31:0] sa, sb;
      longint             p, r;
      longint unsigned    pu;
      gexp_t              g;
      mexp_t              m;
      bit                 gpr, mdu;
      sa = x; sb = y;
      g = '{out: 32'h0, ovf: 1'b0, ill: 1'b0};
      m = '{hi: 32'h0, lo: 32'h0, dbz: 1'b0};
      gpr = 1'b1; mdu = 1'b0;
      case (o)
         6'b100000: begin p = longint'(sa) + longint'(sb); g.out = p[31:0];
                          g.ovf = (p > 64'sd2147483647) || (p < -64'sd2147483648); end
         6'b100001: g.out = x + y;
         6'b100010: begin p = longint'(sa) - longint'(sb); g.out = p[31:0];
                          g.ovf = (p > 64'sd2147483647) || (p < -64'sd2147483648); end
         6'b100011: g.out = x - y;
         6'b100100: g.out = x & y;
         6'b100101: g.out = x | y;
         6'b100110: g.out = x ^ y;
         6'b100111: g.out = ~(x | y);
         6'b101010: g.out = (sa < sb) ? 32'd1 : 32'd0;
         6'b101011: g.out = (x < y) ? 32'd1 : 32'd0;
         6'b000000: g.out = y << s;
         6'b000010: g.out = y >> s;
         6'b000011: g.out = sb >>> s;
         6'b000100: g.out = y << x[4:0];
         6'b000110: g.out = y >> x[4:0];
         6'b000111: g.out = sb >>> x[4:0];
         6'b001111: g.out = y << 16;
         6'b010000: g.out = m_hi;
         6'b010010: g.out = m_lo;
         6'b010001: begin gpr = 1'b0; m_hi = x; end
         6'b010011: begin gpr = 1'b0; m_lo = x; end
         6'b011000: begin gpr = 1'b0; mdu = 1'b1; p = longint'(sa) * longint'(sb);
                          m.hi = p[63:32]; m.lo = p[31:0]; end
         6'b011001: begin gpr = 1'b0; mdu = 1'b1; pu = 64'(x) * 64'(y);
                          m.hi = pu[63:32]; m.lo = pu[31:0]; end
         6'b011010: begin gpr = 1'b0; mdu = 1'b1;
                          if (y == 32'd0) m = '{hi: x, lo: 32'hFFFFFFFF, dbz: 1'b1};
                          else begin
                             p = longint'(sa) / longint'(sb);
                             r = longint'(sa) % longint'(sb);
                             m.hi = r[31:0]; m.lo = p[31:0];
                          end
                    end
         6'b011011: begin gpr = 1'b0; mdu = 1'b1;
                          if (y == 32'd0) m = '{hi: x, lo: 32'hFFFFFFFF, dbz: 1'b1};
                          else begin m.hi = x % y; m.lo = x / y; end
                    end
         default:   begin g.out = 32'hFFFFFFFF; g.ill = 1'b1; end
      endcase
      if (gpr) gq.push_back(g);
      if (mdu) begin
         mq.push_back(m);
         m_hi = m.hi;
         m_lo = m.lo;
      end
   endtask

   task automatic issue(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] s);
      int guard;
      model_op(o, x, y, s);
      @(negedge CLK);
      in_valid = 1'b1; op = o; a = x; b = y; shamt = s;
      guard = 0;
      while (stall && guard < 200) begin
         @(negedge CLK);
         guard++;
      end
      if (stall) begin
         n_checks++;
         $display("FAIL accept_timeout actual=stall_high required=stall_low");
         $fatal(1, "stall never released");
      end
      @(posedge CLK);
      #1 in_valid = 1'b0;
   endtask

   function automatic logic [5:0] pick_op();
      logic [5:0] t;
      case ($urandom_range(0, 29))
         0:  t = 6'b100000;  1:  t = 6'b100001;  2:  t = 6'b100010;  3:  t = 6'b100011;
         4:  t = 6'b100100;  5:  t = 6'b100101;  6:  t = 6'b100110;  7:  t = 6'b100111;
         8:  t = 6'b101010;  9:  t = 6'b101011;  10: t = 6'b000000;  11: t = 6'b000010;
         12: t = 6'b000011;  13: t = 6'b000100;  14: t = 6'b000110;  15: t = 6'b000111;
         16: t = 6'b001111;  17: t = 6'b010000;  18: t = 6'b010010;  19: t = 6'b010001;
         20: t = 6'b010011;  21: t = 6'b011000;  22: t = 6'b011001;  23: t = 6'b011010;
         24: t = 6'b011011;  25: t = 6'b010000;  26: t = 6'b010010;  27: t = 6'b111111;
         28: t = 6'b001000;
         default: t = 6'($urandom_range(0, 63));
      endcase
      return t;
   endfunction

   function automatic logic [31:0] pick_val();
      logic [31:0] v;
      case ($urandom_range(0, 6))
         0:       v = 32'h0;
         1:       v = 32'h80000000;
         2:       v = 32'hFFFFFFFF;
         3:       v = 32'h7FFFFFFF;
         4:       v = 32'($urandom_range(0, 20));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Monitor: pops expectations whenever the DUT presents a result
   always @(negedge CLK) begin
      if (out_valid) begin
         if (gq.size() == 0) begin
            n_checks++;
            $display("FAIL spurious_out_valid actual=1 required=0");
         end else begin
            ge = gq.pop_front();
            chk("gpr_out", 64'(out), 64'(ge.out));
            chk("gpr_ovf_illegal", {62'd0, ovf, illegal}, {62'd0, ge.ovf, ge.ill});
         end
      end
      if (stall) begin
         stall_cnt++;
      end else begin
         if (prev_stall && !skip_mdu) begin
            if (mq.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_mdu_done actual=done required=none");
            end else begin
               me = mq.pop_front();
               chk("mdu_hi", 64'(hi), 64'(me.hi));
               chk("mdu_lo", 64'(lo), 64'(me.lo));
               chk("mdu_div_by_zero", 64'(div_by_zero), 64'(me.dbz));
               chk("mdu_stall_cycles", 64'(stall_cnt), 64'd32);
            end
         end else if (div_by_zero) begin
            n_checks++;
            $display("FAIL spurious_div_by_zero actual=1 required=0");
         end
         stall_cnt = 0;
      end
      prev_stall = stall;
   end

   initial begin
      int guard;
      int cnt16;
      RST = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; shamt = '0;
      v16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; sh16 = '0;
      repeat (3) @(negedge CLK);
      chk("rst_out", 64'(out), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);
      chk("rst_illegal", 64'(illegal), 64'd0);
      chk("rst_div_by_zero", 64'(div_by_zero), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      RST = 1'b0;

      issue(6'b100000, 32'h7FFFFFFF, 32'h1, 5'd0);
      issue(6'b100001, 32'h7FFFFFFF, 32'h1, 5'd0);
      issue(6'b100010, 32'h80000000, 32'h1, 5'd0);
      issue(6'b011000, 32'hFFFFFFFD, 32'd7, 5'd0);
      issue(6'b011001, 32'hFFFFFFFF, 32'd2, 5'd0);
      issue(6'b011011, 32'd100, 32'd7, 5'd0);
      issue(6'b011010, 32'hFFFFFFF9, 32'd2, 5'd0);
      issue(6'b011010, 32'h80000000, 32'hFFFFFFFF, 5'd0);
      issue(6'b011010, 32'd5, 32'd0, 5'd0);
      issue(6'b010010, 32'd0, 32'd0, 5'd0);
      issue(6'b010000, 32'd0, 32'd0, 5'd0);
      issue(6'b000011, 32'd0, 32'h80000000, 5'd4);
      issue(6'b000110, 32'd36, 32'hF0, 5'd0);
      issue(6'b001111, 32'd0, 32'h1234, 5'd0);
      issue(6'b111111, 32'd1, 32'd2, 5'd0);
      issue(6'b010001, 32'h1234, 32'd0, 5'd0);
      issue(6'b010000, 32'd0, 32'd0, 5'd0);
      issue(6'b010011, 32'hABCD, 32'd0, 5'd0);
      issue(6'b010010, 32'd0, 32'd0, 5'd0);

      // Reset ten cycles into a MULT aborts it
      @(negedge CLK);
      skip_mdu = 1'b1;
      in_valid = 1'b1; op = 6'b011000; a = 32'hFFFFFFFD; b = 32'd7;
      @(posedge CLK);
      #1 in_valid = 1'b0;
      repeat (9) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      chk("abort_stall", 64'(stall), 64'd0);
      chk("abort_hi", 64'(hi), 64'd0);
      chk("abort_lo", 64'(lo), 64'd0);
      chk("abort_div_by_zero", 64'(div_by_zero), 64'd0);
      m_hi = '0; m_lo = '0;
      @(posedge CLK);
      #1 skip_mdu = 1'b0;

      // Reset and in_valid together: op must not be taken
      @(negedge CLK);
      RST = 1'b1; in_valid = 1'b1; op = 6'b010001; a = 32'h55;
      @(negedge CLK);
      op = 6'b100001; a = 32'd3; b = 32'd4;
      @(negedge CLK);
      RST = 1'b0; in_valid = 1'b0;
      chk("rst_wins_hi", 64'(hi), 64'd0);
      chk("rst_wins_stall", 64'(stall), 64'd0);

      for (int i = 0; i < 150; i++) begin
         issue(pick_op(), pick_val(), pick_val(), 5'($urandom_range(0, 31)));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge CLK);
      end

      guard = 0;
      while (stall && guard < 100) begin
         @(negedge CLK);
         guard++;
      end
      repeat (3) @(negedge CLK);
      chk("drain_gpr_queue", 64'(gq.size()), 64'd0);
      chk("drain_mdu_queue", 64'(mq.size()), 64'd0);

      // W=16 instance: MULT -3 * 7
      @(negedge CLK);
      v16 = 1'b1; op16 = 6'b011000; a16 = 16'hFFFD; b16 = 16'd7;
      @(posedge CLK);
      #1 v16 = 1'b0;
      cnt16 = 0;
      @(negedge CLK);
      while (stall16 && cnt16 < 100) begin
         cnt16++;
         @(negedge CLK);
      end
      chk("w16_stall_cycles", 64'(cnt16), 64'd16);
      chk("w16_hi", 64'(hi16), 64'h0000FFFF);
      chk("w16_lo", 64'(lo16), 64'h0000FFEB);
      chk("w16_no_out_valid", 64'(ov16), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
